// File: rtl/ac97_rx_deframer.sv
// AC-link receive deframer: locks to SYNC, extracts tag, status and PCM slots.
// Define AC97_RX_PCM_EN to capture slot3/slot4 onto rx_pcm_left/rx_pcm_right.
module ac97_rx_deframer #(
    parameter int LOCK_FRAMES = 2
) (
    input  logic        ac97_bitclk,
    input  logic        ac97_rst,
    input  logic        ac97_sync,
    input  logic        ac97_sdata_in,
    output logic        rx_strobe,
    output logic [15:0] rx_tag,
    output logic [6:0]  rx_status_addr,
    output logic [15:0] rx_status_data,
    output logic        rx_status_new,
    output logic [19:0] rx_pcm_left,
    output logic [19:0] rx_pcm_right,
    output logic        rx_locked,
    output logic        rx_sync_err
);

    typedef enum logic [1:0] {
        HUNT,
        ALIGN,
        LOCKED
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    state_t      state_q;
    state_t      state_d;
    logic        sync_q;
    logic        sync_edge;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic [3:0]  good_q;
    logic [3:0]  good_d;
    logic [3:0]  good_inc;
    logic        deliver;
    logic        err_d;
    logic        capture;
    logic        status_ok;

    logic [15:0] tag_sh;
    logic [6:0]  addr_sh;
    logic [15:0] data_sh;

    assign sync_edge = ac97_sync & ~sync_q;
    assign good_inc  = (good_q == 4'hF) ? good_q : good_q + 4'd1;
    assign status_ok = &tag_sh[15:13];
    assign rx_locked = (state_q == LOCKED);

    // Previous-cycle SYNC sample for edge detection
    always_ff @(posedge ac97_bitclk) begin
        if (ac97_rst) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= ac97_sync;
        end
    end

    // Frame tracker state, bit counter and good-frame counter
    always_ff @(posedge ac97_bitclk) begin
        if (ac97_rst) begin
            state_q <= HUNT;
            cnt_q   <= 8'd0;
            good_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            good_q  <= good_d;
        end
    end

    // Next-state: judge each edge against the bit counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        good_d  = good_q;
        deliver = 1'b0;
        err_d   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            HUNT: begin
                cnt_d = 8'd0;
                if (sync_edge) begin
                    state_d = ALIGN;
                    good_d  = 4'd0;
                end
            end
            ALIGN, LOCKED: begin
                capture = 1'b1;
                if (sync_edge) begin
                    cnt_d = 8'd0;
                    if (cnt_q == 8'd255) begin
                        good_d = good_inc;
                        if (good_inc >= LOCK_N) begin
                            state_d = LOCKED;
                            deliver = 1'b1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        good_d  = 4'd0;
                        state_d = ALIGN;
                    end
                end else if (cnt_q == 8'd255) begin
                    err_d   = 1'b1;
                    state_d = HUNT;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = HUNT;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Shift in only the slot bits that reach an output
    always_ff @(posedge ac97_bitclk) begin
        if (ac97_rst) begin
            tag_sh  <= '0;
            addr_sh <= '0;
            data_sh <= '0;
        end else if (capture) begin
            if (cnt_q < 8'd16) begin
                tag_sh <= {tag_sh[14:0], ac97_sdata_in};
            end
            if (cnt_q >= 8'd17 && cnt_q <= 8'd23) begin
                addr_sh <= {addr_sh[5:0], ac97_sdata_in};
            end
            if (cnt_q >= 8'd36 && cnt_q <= 8'd51) begin
                data_sh <= {data_sh[14:0], ac97_sdata_in};
            end
        end
    end

    // Registered frame outputs and one-cycle pulses
    always_ff @(posedge ac97_bitclk) begin
        if (ac97_rst) begin
            rx_strobe      <= 1'b0;
            rx_sync_err    <= 1'b0;
            rx_status_new  <= 1'b0;
            rx_tag         <= '0;
            rx_status_addr <= '0;
            rx_status_data <= '0;
        end else begin
            rx_strobe     <= deliver;
            rx_sync_err   <= err_d;
            rx_status_new <= deliver & status_ok;
            if (deliver) begin
                rx_tag <= tag_sh;
                if (status_ok) begin
                    rx_status_addr <= addr_sh;
                    rx_status_data <= data_sh;
                end
            end
        end
    end

`ifdef AC97_RX_PCM_EN
    logic [19:0] left_sh;
    logic [19:0] right_sh;

    // Slot3/slot4 capture and presentation
    always_ff @(posedge ac97_bitclk) begin
        if (ac97_rst) begin
            left_sh      <= '0;
            right_sh     <= '0;
            rx_pcm_left  <= '0;
            rx_pcm_right <= '0;
        end else begin
            if (capture && cnt_q >= 8'd56 && cnt_q <= 8'd75) begin
                left_sh <= {left_sh[18:0], ac97_sdata_in};
            end
            if (capture && cnt_q >= 8'd76 && cnt_q <= 8'd95) begin
                right_sh <= {right_sh[18:0], ac97_sdata_in};
            end
            if (deliver) begin
                rx_pcm_left  <= left_sh;
                rx_pcm_right <= right_sh;
            end
        end
    end
`else
    assign rx_pcm_left  = '0;
    assign rx_pcm_right = '0;
`endif

endmodule

// File: tb/tb_ac97_rx_deframer.sv
// Bench for ac97_rx_deframer: random frames vs a frame-level reference model.
// Honours AC97_RX_PCM_EN for the expected PCM outputs.
module tb_ac97_rx_deframer;

    localparam int LOCK = 2;

    logic        ac97_bitclk = 1'b0;
    logic        ac97_rst = 1'b1;
    logic        ac97_sync = 1'b0;
    logic        ac97_sdata_in = 1'b0;
    logic        rx_strobe;
    logic [15:0] rx_tag;
    logic [6:0]  rx_status_addr;
    logic [15:0] rx_status_data;
    logic        rx_status_new;
    logic [19:0] rx_pcm_left;
    logic [19:0] rx_pcm_right;
    logic        rx_locked;
    logic        rx_sync_err;

    ac97_rx_deframer #(.LOCK_FRAMES(LOCK)) dut (
        .ac97_bitclk   (ac97_bitclk),
        .ac97_rst      (ac97_rst),
        .ac97_sync     (ac97_sync),
        .ac97_sdata_in (ac97_sdata_in),
        .rx_strobe     (rx_strobe),
        .rx_tag        (rx_tag),
        .rx_status_addr(rx_status_addr),
        .rx_status_data(rx_status_data),
        .rx_status_new (rx_status_new),
        .rx_pcm_left   (rx_pcm_left),
        .rx_pcm_right  (rx_pcm_right),
        .rx_locked     (rx_locked),
        .rx_sync_err   (rx_sync_err)
    );

    always #5 ac97_bitclk = ~ac97_bitclk;

    int tests = 0;
    int fails = 0;
    int tail = 0;
    int strobes = 0;
    int exp_strobes = 0;
    int errs = 0;
    int exp_errs = 0;

    // reference model: 0 hunt, 1 aligning, 2 locked
    int          m_state = 0;
    int          m_good = 0;
    logic [15:0] e_tag = '0;
    logic [6:0]  e_addr = '0;
    logic [15:0] e_data = '0;
    logic [19:0] e_l = '0;
    logic [19:0] e_r = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one bit period; SYNC stays high 16 cycles after a requested edge
    task automatic tick(input logic edge_req, input logic sd);
        ac97_sync = edge_req || (tail > 0);
        if (edge_req) tail = 15;
        else if (tail > 0) tail--;
        ac97_sdata_in = sd;
        @(posedge ac97_bitclk);
        #1;
        if (rx_strobe) strobes++;
        if (rx_sync_err) errs++;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [255:0] mk(input logic [15:0] t,
            input logic [19:0] s1, input logic [19:0] s2,
            input logic [19:0] s3, input logic [19:0] s4);
        logic [255:0] f;
        for (int k = 0; k < 256; k++) f[k] = rbit();
        for (int k = 0; k < 16; k++) f[k] = t[15-k];
        for (int j = 0; j < 20; j++) begin
            f[16+j] = s1[19-j];
            f[36+j] = s2[19-j];
            f[56+j] = s3[19-j];
            f[76+j] = s4[19-j];
        end
        return f;
    endfunction

    task automatic check_outputs(input string nm);
        chk({nm, ".tag"}, 32'(rx_tag), 32'(e_tag));
        chk({nm, ".addr"}, 32'(rx_status_addr), 32'(e_addr));
        chk({nm, ".data"}, 32'(rx_status_data), 32'(e_data));
        chk({nm, ".pcm_l"}, 32'(rx_pcm_left), 32'(e_l));
        chk({nm, ".pcm_r"}, 32'(rx_pcm_right), 32'(e_r));
    endtask

    task automatic check_reset(input string nm);
        chk({nm, ".strobe"}, 32'(rx_strobe), 32'd0);
        chk({nm, ".new"}, 32'(rx_status_new), 32'd0);
        chk({nm, ".locked"}, 32'(rx_locked), 32'd0);
        chk({nm, ".err"}, 32'(rx_sync_err), 32'd0);
        check_outputs(nm);
    endtask

    task automatic do_reset();
        m_state = 0;
        m_good = 0;
        e_tag = '0;
        e_addr = '0;
        e_data = '0;
        e_l = '0;
        e_r = '0;
    endtask

    task automatic open_edge();
        tick(1'b1, rbit());
        if (m_state == 0) begin
            m_state = 1;
            m_good = 0;
        end
        chk("open.locked", 32'(rx_locked), 32'(m_state == 2));
        chk("open.strobe", 32'(rx_strobe), 32'd0);
    endtask

    // full 256-bit frame closed by an on-time edge
    task automatic good_frame(input logic [15:0] t, input logic [19:0] s1,
            input logic [19:0] s2, input logic [19:0] s3,
            input logic [19:0] s4);
        logic [255:0] fr;
        logic dlv;
        logic st;
        fr = mk(t, s1, s2, s3, s4);
        for (int k = 0; k < 255; k++) begin
            tick(1'b0, fr[k]);
            if (k == 0) begin
                chk("pulse_end.strobe", 32'(rx_strobe), 32'd0);
                chk("pulse_end.err", 32'(rx_sync_err), 32'd0);
            end
        end
        tick(1'b1, fr[255]);
        m_good = (m_good < 15) ? m_good + 1 : 15;
        if (m_good >= LOCK) m_state = 2;
        dlv = (m_state == 2);
        st = dlv && (t[15:13] == 3'b111);
        if (dlv) begin
            exp_strobes++;
            e_tag = t;
`ifdef AC97_RX_PCM_EN
            e_l = s3;
            e_r = s4;
`endif
            if (st) begin
                e_addr = s1[18:12];
                e_data = s2[19:4];
            end
        end
        chk("frame.strobe", 32'(rx_strobe), 32'(dlv));
        chk("frame.locked", 32'(rx_locked), 32'(dlv));
        chk("frame.err", 32'(rx_sync_err), 32'd0);
        chk("frame.new", 32'(rx_status_new), 32'(st));
        check_outputs("frame");
    endtask

    task automatic rand_frame();
        logic [15:0] t;
        t = 16'($urandom);
        if (rbit()) t[15:13] = 3'b111;
        good_frame(t, 20'($urandom), 20'($urandom), 20'($urandom),
                   20'($urandom));
    endtask

    // edge arrives while the bit counter is at n
    task automatic early_frame(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, rbit());
        tick(1'b1, rbit());
        m_state = 1;
        m_good = 0;
        exp_errs++;
        chk("early.err", 32'(rx_sync_err), 32'd1);
        chk("early.strobe", 32'(rx_strobe), 32'd0);
        chk("early.locked", 32'(rx_locked), 32'd0);
        check_outputs("early");
    endtask

    initial begin
        // reset with SYNC low
        repeat (3) tick(1'b0, 1'b1);
        check_reset("reset");
        ac97_rst = 1'b0;

        // acquisition: lock and first strobe after the 3rd edge
        open_edge();
        rand_frame();
        rand_frame();
        repeat (4) rand_frame();

        // status accepted, then tag without slot valids
        good_frame(16'hE000, 20'h26000, 20'h0F0F0, 20'hABCDE, 20'h12345);
        chk("status.addr", 32'(rx_status_addr), 32'h26);
        chk("status.data", 32'(rx_status_data), 32'h0F0F);
        good_frame(16'h8000, 20'h7FFFF, 20'hFFFFF, 20'h11111, 20'h22222);
        chk("nostatus.tag", 32'(rx_tag), 32'h8000);
        chk("nostatus.addr", 32'(rx_status_addr), 32'h26);

        // early edge at counter 100, relock after two good frames
        early_frame(100);
        rand_frame();
        rand_frame();
        rand_frame();

        // omitted edge -> HUNT, silence, reacquire
        for (int k = 0; k < 256; k++) tick(1'b0, rbit());
        m_state = 0;
        exp_errs++;
        chk("omit.err", 32'(rx_sync_err), 32'd1);
        chk("omit.locked", 32'(rx_locked), 32'd0);
        repeat (300) tick(1'b0, rbit());
        chk("hunt.locked", 32'(rx_locked), 32'd0);
        open_edge();
        rand_frame();
        rand_frame();

        // reset mid-frame at counter 128
        for (int k = 0; k < 128; k++) tick(1'b0, rbit());
        ac97_rst = 1'b1;
        tick(1'b0, rbit());
        do_reset();
        check_reset("midreset");

        // SYNC high through reset release gives an immediate edge
        ac97_sync = 1'b1;
        tail = 0;
        @(posedge ac97_bitclk);
        #1;
        ac97_rst = 1'b0;
        open_edge();
        rand_frame();
        rand_frame();
        rand_frame();

        chk("strobe_count", 32'(strobes), 32'(exp_strobes));
        chk("err_count", 32'(errs), 32'(exp_errs));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ac97_rx_deframer.md
AC97_RX_DEFRAMER -- requirements
Module: ac97_rx_deframer

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 2: consecutive correctly spaced frames required before lock (legal range 1..15).
REQ-002 SHALL have port ac97_bitclk, in, 1: the only clock; all sampling and state changes occur on its rising edge.
REQ-003 SHALL have port ac97_rst, in, 1: reset, synchronous, active-high.
REQ-004 SHALL have port ac97_sync, in, 1: AC-link SYNC as driven to the codec, retimed to ac97_bitclk.
REQ-005 SHALL have port ac97_sdata_in, in, 1: codec serial data, retimed to ac97_bitclk.
REQ-006 SHALL have port rx_strobe, out, 1: one-cycle pulse; all frame outputs updated this cycle.
REQ-007 SHALL have port rx_tag, out, 16: received tag slot; rx_tag[15] is codec ready.
REQ-008 SHALL have port rx_status_addr, out, 7: slot1 bits 18:12 from the last accepted status frame.
REQ-009 SHALL have port rx_status_data, out, 16: slot2 bits 19:4 from the last accepted status frame.
REQ-010 SHALL have port rx_status_new, out, 1: one-cycle pulse, coincident with rx_strobe, when status outputs were updated.
REQ-011 SHALL have ports rx_pcm_left and rx_pcm_right, out, 20 each: slot3 and slot4 contents.
REQ-012 SHALL have ports rx_locked, out, 1 (state==LOCKED) and rx_sync_err, out, 1 (one-cycle error pulse).

Function
REQ-013 Edge cycle: cycle where ac97_sync samples 1 and its previous-cycle sample was 0; sdata sampled in an edge cycle is bit 255 of the ending frame.
REQ-014 Bit 0 of a frame is sampled the cycle after its opening edge; bits are MSB-first: bits 0..15 tag (bit 0 = tag[15]), slot n occupies bits 16+20(n-1) .. 35+20(n-1), first bit = slot bit 19.
REQ-015 An 8-bit bit counter SHALL count 0..255, cleared to 0 on the cycle after any edge that opens a frame.
REQ-016 States: HUNT, ALIGN, LOCKED; one good-frame counter (4 bits).
REQ-017 HUNT: on edge cycle -> ALIGN, good count 0, frame reception starts; otherwise stay, sample nothing.
REQ-018 ALIGN/LOCKED, edge with counter==255: good frame; good count saturating-increments; if result >= LOCK_FRAMES, state LOCKED; next frame opens immediately.
REQ-019 A good frame whose closing edge leaves state LOCKED SHALL be delivered: rx_strobe=1 the cycle after the closing edge, outputs valid from that cycle until next delivery.
REQ-020 Edge with counter!=255: rx_sync_err pulse next cycle, frame discarded (no strobe), good count 0, state ALIGN, new frame opens at this edge.
REQ-021 Counter==255 with no edge: rx_sync_err pulse next cycle, frame discarded, state HUNT.
REQ-022 On delivery rx_tag and PCM outputs SHALL always update; rx_status_addr/data and rx_status_new SHALL update only if tag[15], tag[14] and tag[13] are all 1, else hold.
REQ-023 ac97_sync high for more than one cycle SHALL not create further edges; sync width is not checked.
REQ-024 Output latency from bit 255 sampled to rx_strobe SHALL be exactly 1 cycle.

Reset
REQ-025 Reset SHALL force HUNT, bit counter 0, good count 0, and every output 0 on the next edge, discarding any partial frame.
REQ-026 Reset SHALL take priority over simultaneous sync edges; the previous-sync register also clears to 0, so sync held high through reset release yields an edge on the first post-reset cycle.

Configuration
REQ-027 Macro AC97_RX_PCM_EN defined: slot3/slot4 captured and presented per REQ-011/REQ-022.
REQ-028 Macro AC97_RX_PCM_EN undefined: slot3/slot4 storage absent, rx_pcm_left and rx_pcm_right tied to 0; all other behaviour unchanged.

Verification
REQ-029 LOCK_FRAMES=2, sync edges every 256 cycles from reset release -> rx_locked rises 1 cycle after 3rd edge; first rx_strobe same cycle; strobes every 256 cycles thereafter.
REQ-030 Locked, frame tag=16'hE000, slot1=20'h26000, slot2=20'h0F0F0 -> rx_status_addr=7'h26, rx_status_data=16'h0F0F, rx_status_new=1 with rx_strobe.
REQ-031 Locked, tag=16'h8000 with slot1/slot2 nonzero -> rx_status_new=0, status outputs unchanged, rx_tag=16'h8000.
REQ-032 Locked, edge arrives at counter 100 -> rx_sync_err 1 cycle, no strobe, rx_locked 0, relock after 2 good frames from that edge.
REQ-033 Locked, sync edge omitted -> rx_sync_err at counter 255+1, state HUNT, no strobes until re-acquired.
REQ-034 Slot3=20'hABCDE, slot4=20'h12345 with AC97_RX_PCM_EN -> pcm outputs match; without macro -> both 0; ac97_rst at counter 128 -> all outputs 0, HUNT.
